iir_sample_scheduler: RTL and testbench
=======================================

IIR_SAMPLE_SCHEDULER -- requirements
Module: iir_sample_scheduler

Interface
REQ-001 Parameter: DATA_W, default 16, sample width in bits for input, core and output samples.
REQ-002 Parameter: CNT_W, default 16, width of the per-channel processed-sample counters.
REQ-003 ACLK  input  1  single clock; all state updates on rising edge.
REQ-004 ARESET  input  1  reset, synchronous, active-high.
REQ-005 s0_valid / s0_data / s0_ready  in / in / out  1 / DATA_W / 1  channel-0 sample stream.
REQ-006 s1_valid / s1_data / s1_ready  in / in / out  1 / DATA_W / 1  channel-1 sample stream.
REQ-007 core_start / core_ch / core_x  out / out / out  1 / 1 / DATA_W  filter-core launch pulse, channel select (state bank), input sample.
REQ-008 core_done / core_y  in / in  1 / DATA_W  filter-core completion pulse and result.
REQ-009 m_valid / m_ch / m_data / m_ready  out / out / out / in  1 / 1 / DATA_W / 1  tagged output stream.
REQ-010 cfg_req / cfg_grant  in / out  1 / 1  coefficient-reload request and exclusive-access grant.
REQ-011 cnt0 / cnt1  out / out  CNT_W / CNT_W  samples completed per channel.

Function
REQ-012 Each channel SHALL have a one-entry holding register; sN_ready = !holdN_valid; a transfer occurs on sN_valid & sN_ready.
REQ-013 FSM states: IDLE, ISSUE, WAIT, OUT, CFG.
REQ-014 IDLE: if cfg_req=1, go to CFG (cfg_req has priority over pending samples).
REQ-015 IDLE, no cfg_req, ≥1 hold valid: grant round-robin; pointer selects preferred channel; on grant the pointer moves to the other channel; go to ISSUE.
REQ-016 ISSUE: core_start=1 for exactly one cycle with core_ch/core_x from the granted hold; that hold is cleared in the same cycle; go to WAIT.
REQ-017 WAIT: core_x/core_ch held stable; on core_done capture core_y into the output register, set m_valid, go to OUT.
REQ-018 OUT: m_valid held with stable m_ch/m_data until m_ready=1; on handshake increment the matching cntN (wrap modulo 2^CNT_W); return to IDLE.
REQ-019 CFG: cfg_grant=1; remain while cfg_req=1; on cfg_req=0 deassert cfg_grant next cycle and return to IDLE. No core_start while cfg_grant=1.
REQ-020 cfg_req asserted in ISSUE/WAIT/OUT SHALL be held off until the in-flight sample completes through OUT.
REQ-021 Holding registers SHALL accept new samples in every state, including CFG and WAIT.
REQ-022 Same-cycle hold clear (ISSUE) and new accept on the same channel SHALL NOT occur (ready was 0); a hold freed in ISSUE reads ready=1 from the next cycle.
REQ-023 Minimum sample latency: s accept -> core_start 2 cycles; core_done -> m_valid 1 cycle; back-to-back throughput one sample per (core latency + 3) cycles when m_ready=1.
REQ-024 core_done outside WAIT SHALL be ignored.

Reset
REQ-025 ARESET=1 SHALL force IDLE, hold valids=0, pointer=channel 0, core_start=0, core_ch=0, core_x=0, m_valid=0, m_ch=0, m_data=0, cfg_grant=0, cnt0=cnt1=0; s0_ready=s1_ready=1 from the first cycle after reset release.
REQ-026 Reset asserted mid-operation (WAIT/OUT/CFG) SHALL abandon the in-flight sample and drop cfg_grant in the next cycle.

Verification
REQ-027 Single sample: s0_data=0x1234, core returns 0x5678 after 4 cycles -> one core_start with core_ch=0, core_x=0x1234; m_ch=0, m_data=0x5678; cnt0=1.
REQ-028 Both channels valid simultaneously after reset -> grant order ch0, ch1, ch0, ch1 (pointer alternates); cnt0=cnt1=2 after four samples.
REQ-029 m_ready held 0 for 10 cycles in OUT -> m_valid, m_data stable; no further core_start; s1 still accepted into its hold.
REQ-030 cfg_req raised during WAIT -> cfg_grant=1 only after OUT handshake; no core_start while granted; pending sample issued after cfg_req drops.
REQ-031 cnt0 preset by 65535 completions -> next completion wraps cnt0 to 0.
REQ-032 ARESET pulsed during WAIT -> all outputs at reset values next cycle; late core_done ignored; no m_valid.

Source files
------------

// File: rtl/iir_sample_scheduler.sv
//----------------------------------------------------------------------------
// Module   : iir_sample_scheduler
// Purpose  : Two-channel sample scheduler for a shared, banked IIR filter core.
//            Arbitrates round-robin and arbitrates coefficient-reload access.
// Revision : 1.0  initial release
//----------------------------------------------------------------------------
`default_nettype none

module iir_sample_scheduler #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              s0_valid,
  input  logic [DATA_W-1:0] s0_data,
  output logic              s0_ready,
  input  logic              s1_valid,
  input  logic [DATA_W-1:0] s1_data,
  output logic              s1_ready,
  output logic              core_start,
  output logic              core_ch,
  output logic [DATA_W-1:0] core_x,
  input  logic              core_done,
  input  logic [DATA_W-1:0] core_y,
  output logic              m_valid,
  output logic              m_ch,
  output logic [DATA_W-1:0] m_data,
  input  logic              m_ready,
  input  logic              cfg_req,
  output logic              cfg_grant,
  output logic [CNT_W-1:0]  cnt0,
  output logic [CNT_W-1:0]  cnt1
);

  localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_OUT   = 3'd3,
    ST_CFG   = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_hold0_v;
  logic              r_hold1_v;
  logic [DATA_W-1:0] r_hold0_d;
  logic [DATA_W-1:0] r_hold1_d;
  logic              r_ptr;
  logic              r_core_ch;
  logic [DATA_W-1:0] r_core_x;
  logic              r_m_valid;
  logic              r_m_ch;
  logic [DATA_W-1:0] r_m_data;
  logic [CNT_W-1:0]  r_cnt0;
  logic [CNT_W-1:0]  r_cnt1;
  logic              w_grant;
  logic              w_grant_ch;
  logic              w_issue;
  logic              w_capture;
  logic              w_m_hs;

  // Round-robin only matters when both holds are full; otherwise take the one that is.
  always_comb begin
    w_grant_ch = r_ptr;
    if (r_hold0_v && !r_hold1_v) begin
      w_grant_ch = 1'b0;
    end else if (!r_hold0_v && r_hold1_v) begin
      w_grant_ch = 1'b1;
    end
  end

  assign w_grant   = (r_state == ST_IDLE) && !cfg_req && (r_hold0_v || r_hold1_v);
  assign w_issue   = (r_state == ST_ISSUE);
  assign w_capture = (r_state == ST_WAIT) && core_done;
  assign w_m_hs    = (r_state == ST_OUT) && m_ready;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (cfg_req) begin
          w_state_nxt = ST_CFG;
        end else if (w_grant) begin
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: w_state_nxt = ST_WAIT;
      ST_WAIT:  if (core_done) w_state_nxt = ST_OUT;
      ST_OUT:   if (m_ready) w_state_nxt = ST_IDLE;
      ST_CFG:   if (!cfg_req) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // The issued hold has ready=0 during ISSUE, so clear and accept never collide.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_hold0_v <= 1'b0;
      r_hold1_v <= 1'b0;
      r_hold0_d <= '0;
      r_hold1_d <= '0;
    end else begin
      if (w_issue && !r_core_ch) begin
        r_hold0_v <= 1'b0;
      end else if (s0_valid && !r_hold0_v) begin
        r_hold0_v <= 1'b1;
        r_hold0_d <= s0_data;
      end
      if (w_issue && r_core_ch) begin
        r_hold1_v <= 1'b0;
      end else if (s1_valid && !r_hold1_v) begin
        r_hold1_v <= 1'b1;
        r_hold1_d <= s1_data;
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_ptr     <= 1'b0;
      r_core_ch <= 1'b0;
      r_core_x  <= '0;
      r_m_valid <= 1'b0;
      r_m_ch    <= 1'b0;
      r_m_data  <= '0;
      r_cnt0    <= '0;
      r_cnt1    <= '0;
    end else begin
      if (w_grant) begin
        r_ptr     <= ~w_grant_ch;
        r_core_ch <= w_grant_ch;
        r_core_x  <= w_grant_ch ? r_hold1_d : r_hold0_d;
      end
      if (w_capture) begin
        r_m_valid <= 1'b1;
        r_m_ch    <= r_core_ch;
        r_m_data  <= core_y;
      end else if (w_m_hs) begin
        r_m_valid <= 1'b0;
        if (r_m_ch) begin
          r_cnt1 <= r_cnt1 + c_cnt_one;
        end else begin
          r_cnt0 <= r_cnt0 + c_cnt_one;
        end
      end
    end
  end

  assign s0_ready   = !r_hold0_v;
  assign s1_ready   = !r_hold1_v;
  assign core_start = w_issue;
  assign core_ch    = r_core_ch;
  assign core_x     = r_core_x;
  assign m_valid    = r_m_valid;
  assign m_ch       = r_m_ch;
  assign m_data     = r_m_data;
  assign cfg_grant  = (r_state == ST_CFG);
  assign cnt0       = r_cnt0;
  assign cnt1       = r_cnt1;

endmodule

`default_nettype wire

// File: tb/tb_iir_sample_scheduler.sv
//----------------------------------------------------------------------------
// Module   : tb_iir_sample_scheduler
// Purpose  : Directed self-checking bench; the core model returns x ^ 0x444C.
// Revision : 1.0  initial release
//----------------------------------------------------------------------------
`default_nettype none

module tb_iir_sample_scheduler;

  localparam int DW = 16;
  localparam int CW = 4;

  logic          ACLK = 1'b0;
  logic          ARESET = 1'b1;
  logic          s0_valid = 1'b0;
  logic [DW-1:0] s0_data = '0;
  logic          s0_ready;
  logic          s1_valid = 1'b0;
  logic [DW-1:0] s1_data = '0;
  logic          s1_ready;
  logic          core_start;
  logic          core_ch;
  logic [DW-1:0] core_x;
  logic          core_done = 1'b0;
  logic [DW-1:0] core_y = '0;
  logic          m_valid;
  logic          m_ch;
  logic [DW-1:0] m_data;
  logic          m_ready = 1'b0;
  logic          cfg_req = 1'b0;
  logic          cfg_grant;
  logic [CW-1:0] cnt0;
  logic [CW-1:0] cnt1;

  int n_pass = 0;
  int n_total = 0;

  iir_sample_scheduler #(.DATA_W(DW), .CNT_W(CW)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .s0_valid(s0_valid), .s0_data(s0_data), .s0_ready(s0_ready),
    .s1_valid(s1_valid), .s1_data(s1_data), .s1_ready(s1_ready),
    .core_start(core_start), .core_ch(core_ch), .core_x(core_x),
    .core_done(core_done), .core_y(core_y),
    .m_valid(m_valid), .m_ch(m_ch), .m_data(m_data), .m_ready(m_ready),
    .cfg_req(cfg_req), .cfg_grant(cfg_grant), .cnt0(cnt0), .cnt1(cnt1)
  );

  always #5 ACLK = ~ACLK;

  // Filter core model: done pulse 4 cycles after the start cycle; ignores ARESET.
  logic          core_busy = 1'b0;
  logic [2:0]    core_lat = '0;
  logic [DW-1:0] core_xcap = '0;
  always @(posedge ACLK) begin
    core_done <= 1'b0;
    if (core_start) begin
      core_busy <= 1'b1;
      core_lat  <= 3'd3;
      core_xcap <= core_x;
    end else if (core_busy) begin
      if (core_lat == 3'd0) begin
        core_done <= 1'b1;
        core_y    <= core_xcap ^ 16'h444C;
        core_busy <= 1'b0;
      end else begin
        core_lat <= core_lat - 3'd1;
      end
    end
  end

  int            n_start = 0;
  int            n_bad = 0;
  int            n_out = 0;
  logic          order [0:7];
  logic [DW-1:0] outd [0:7];
  always @(posedge ACLK) begin
    if (ARESET) begin
      n_start <= 0;
      n_bad   <= 0;
      n_out   <= 0;
    end else begin
      if (core_start) begin
        order[n_start[2:0]] <= core_ch;
        n_start <= n_start + 1;
        if (cfg_grant) n_bad <= n_bad + 1;
      end
      if (m_valid && m_ready) begin
        outd[n_out[2:0]] <= m_data;
        n_out <= n_out + 1;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge ACLK);
  endtask

  task automatic do_reset();
    @(negedge ACLK);
    ARESET = 1'b1; s0_valid = 1'b0; s1_valid = 1'b0; m_ready = 1'b0; cfg_req = 1'b0;
    tick(2);
    ARESET = 1'b0;
  endtask

  task automatic push(input bit ch, input logic [DW-1:0] d, output bit ok);
    int t;
    t = 0;
    @(negedge ACLK);
    if (ch) begin s1_valid = 1'b1; s1_data = d; end
    else    begin s0_valid = 1'b1; s0_data = d; end
    while (((ch ? s1_ready : s0_ready) == 1'b0) && t < 100) begin
      @(negedge ACLK);
      t++;
    end
    ok = (t < 100);
    @(negedge ACLK);
    if (ch) s1_valid = 1'b0; else s0_valid = 1'b0;
  endtask

  // which: 0 = m_valid, 1 = core_start, 2 = core_done
  task automatic wait_for(input int which, output bit ok);
    int t;
    t = 0;
    while (t < 60 && !((which == 0) ? m_valid : (which == 1) ? core_start : core_done)) begin
      @(negedge ACLK);
      t++;
    end
    ok = (t < 60);
  endtask

  task automatic handshake();
    m_ready = 1'b1;
    @(negedge ACLK);
    m_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_total++; if ({s0_ready, s1_ready} !== 2'b11) $display("FAIL reset_ready: got %b want 11", {s0_ready, s1_ready}); else n_pass++;
    n_total++; if ({core_start, core_ch, core_x} !== 18'h0) $display("FAIL reset_core: got %h want 0", {core_start, core_ch, core_x}); else n_pass++;
    n_total++; if ({m_valid, m_ch, m_data} !== 18'h0) $display("FAIL reset_m: got %h want 0", {m_valid, m_ch, m_data}); else n_pass++;
    n_total++; if ({cfg_grant, cnt0, cnt1} !== 9'h0) $display("FAIL reset_cfg_cnt: got %h want 0", {cfg_grant, cnt0, cnt1}); else n_pass++;
  endtask

  task automatic test_single();
    bit ok;
    do_reset();
    push(1'b0, 16'h1234, ok);
    n_total++; if (!ok || core_start !== 1'b0) $display("FAIL single_accept: ok=%0b start=%b want 1/0", ok, core_start); else n_pass++;
    tick(1);
    n_total++; if ({core_start, core_ch, core_x, s0_ready} !== {1'b1, 1'b0, 16'h1234, 1'b0})
      $display("FAIL single_issue: got %b %b %h rdy=%b want 1 0 1234 0", core_start, core_ch, core_x, s0_ready); else n_pass++;
    tick(1);
    n_total++; if ({core_start, s0_ready} !== 2'b01) $display("FAIL single_after_issue: got %b want 01", {core_start, s0_ready}); else n_pass++;
    wait_for(2, ok);
    n_total++; if (!ok || m_valid !== 1'b0) $display("FAIL single_done: ok=%0b m_valid=%b want 1/0", ok, m_valid); else n_pass++;
    tick(1);
    n_total++; if ({m_valid, m_ch, m_data} !== {1'b1, 1'b0, 16'h5678}) $display("FAIL single_out: got %b %b %h want 1 0 5678", m_valid, m_ch, m_data); else n_pass++;
    handshake();
    n_total++; if ({m_valid, cnt0, cnt1} !== {1'b0, 4'd1, 4'd0}) $display("FAIL single_cnt: got %b %0d %0d want 0 1 0", m_valid, cnt0, cnt1); else n_pass++;
    n_total++; if (n_start !== 1) $display("FAIL single_nstart: got %0d want 1", n_start); else n_pass++;
  endtask

  task automatic test_round_robin();
    bit ok0a, ok0b, ok1a, ok1b;
    int t;
    do_reset();
    m_ready = 1'b1;
    fork
      begin push(1'b0, 16'h0001, ok0a); push(1'b0, 16'h0003, ok0b); end
      begin push(1'b1, 16'h0002, ok1a); push(1'b1, 16'h0004, ok1b); end
    join
    t = 0;
    while (n_out < 4 && t < 200) begin tick(1); t++; end
    m_ready = 1'b0;
    n_total++; if (!(ok0a && ok0b && ok1a && ok1b) || t >= 200) $display("FAIL rr_timeout: outs=%0d want 4", n_out); else n_pass++;
    n_total++; if ({order[0], order[1], order[2], order[3]} !== 4'b0101)
      $display("FAIL rr_order: got %b%b%b%b want 0101", order[0], order[1], order[2], order[3]); else n_pass++;
    n_total++; if ({cnt0, cnt1} !== {4'd2, 4'd2}) $display("FAIL rr_cnt: got %0d %0d want 2 2", cnt0, cnt1); else n_pass++;
    n_total++; if ({outd[0], outd[1], outd[2], outd[3]} !== {16'h444D, 16'h444E, 16'h444F, 16'h4448})
      $display("FAIL rr_data: got %h %h %h %h want 444d 444e 444f 4448", outd[0], outd[1], outd[2], outd[3]); else n_pass++;
  endtask

  task automatic test_backpressure();
    bit ok, ok1, stable;
    do_reset();
    push(1'b0, 16'h00AA, ok);
    wait_for(0, ok);
    push(1'b1, 16'h00BB, ok1);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if ({m_valid, m_ch, m_data} !== {1'b1, 1'b0, 16'h44E6}) stable = 1'b0;
      tick(1);
    end
    n_total++; if (!ok || !stable) $display("FAIL bp_stable: got %b %b %h want 1 0 44e6", m_valid, m_ch, m_data); else n_pass++;
    n_total++; if (n_start !== 1) $display("FAIL bp_nstart: got %0d want 1", n_start); else n_pass++;
    n_total++; if (!ok1 || s1_ready !== 1'b0) $display("FAIL bp_s1_held: ok=%0b s1_ready=%b want 1/0", ok1, s1_ready); else n_pass++;
    handshake();
    wait_for(1, ok);
    n_total++; if (!ok || {core_ch, core_x} !== {1'b1, 16'h00BB}) $display("FAIL bp_issue1: got %b %h want 1 00bb", core_ch, core_x); else n_pass++;
    wait_for(0, ok);
    n_total++; if (!ok || {m_ch, m_data} !== {1'b1, 16'h44F7}) $display("FAIL bp_out1: got %b %h want 1 44f7", m_ch, m_data); else n_pass++;
    handshake();
    n_total++; if ({cnt0, cnt1} !== {4'd1, 4'd1}) $display("FAIL bp_cnt: got %0d %0d want 1 1", cnt0, cnt1); else n_pass++;
  endtask

  task automatic test_cfg();
    bit ok, ok1, held;
    do_reset();
    push(1'b0, 16'h0011, ok);
    wait_for(1, ok);
    tick(1);
    cfg_req = 1'b1;
    push(1'b1, 16'h0022, ok1);
    n_total++; if (!ok1 || cfg_grant !== 1'b0) $display("FAIL cfg_wait_grant: ok=%0b grant=%b want 1/0", ok1, cfg_grant); else n_pass++;
    wait_for(0, ok);
    n_total++; if (!ok || cfg_grant !== 1'b0) $display("FAIL cfg_out_grant: ok=%0b grant=%b want 1/0", ok, cfg_grant); else n_pass++;
    handshake();
    tick(1);
    held = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (cfg_grant !== 1'b1 || core_start !== 1'b0) held = 1'b0;
      tick(1);
    end
    n_total++; if (!held) $display("FAIL cfg_granted: grant=%b start=%b want 1 0", cfg_grant, core_start); else n_pass++;
    n_total++; if (n_start !== 1) $display("FAIL cfg_nstart: got %0d want 1", n_start); else n_pass++;
    cfg_req = 1'b0;
    tick(1);
    n_total++; if (cfg_grant !== 1'b0) $display("FAIL cfg_release: got %b want 0", cfg_grant); else n_pass++;
    wait_for(1, ok);
    n_total++; if (!ok || {core_ch, core_x} !== {1'b1, 16'h0022}) $display("FAIL cfg_pending: got %b %h want 1 0022", core_ch, core_x); else n_pass++;
    wait_for(0, ok);
    handshake();
    n_total++; if (n_bad !== 0) $display("FAIL cfg_start_during_grant: got %0d want 0", n_bad); else n_pass++;
  endtask

  task automatic test_wrap();
    bit ok, all_ok;
    all_ok = 1'b1;
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      push(1'b0, 16'(i), ok);
      all_ok &= ok;
      wait_for(0, ok);
      all_ok &= ok;
      tick(1);
    end
    n_total++; if (!all_ok || cnt0 !== 4'hF) $display("FAIL wrap_full: got %0d want 15", cnt0); else n_pass++;
    push(1'b0, 16'h00FF, ok);
    wait_for(0, ok);
    tick(1);
    m_ready = 1'b0;
    n_total++; if (!ok || {cnt0, cnt1} !== 8'h00) $display("FAIL wrap_zero: got %0d %0d want 0 0", cnt0, cnt1); else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit ok, saw_done, saw_m;
    do_reset();
    push(1'b0, 16'h0055, ok);
    wait_for(1, ok);
    tick(1);
    ARESET = 1'b1;
    tick(1);
    n_total++; if (!ok || {core_start, core_ch, core_x, m_valid, m_ch, m_data, cfg_grant} !== 37'h0)
      $display("FAIL mid_reset_outs: got %b %b %h %b %b %h %b want all 0", core_start, core_ch, core_x, m_valid, m_ch, m_data, cfg_grant); else n_pass++;
    n_total++; if ({s0_ready, s1_ready} !== 2'b11) $display("FAIL mid_reset_ready: got %b want 11", {s0_ready, s1_ready}); else n_pass++;
    ARESET = 1'b0;
    saw_done = 1'b0;
    saw_m = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (core_done) saw_done = 1'b1;
      if (m_valid) saw_m = 1'b1;
      tick(1);
    end
    n_total++; if (!saw_done || saw_m) $display("FAIL mid_late_done: done_seen=%0b m_valid_seen=%0b want 1 0", saw_done, saw_m); else n_pass++;
    n_total++; if (n_start !== 0) $display("FAIL mid_nstart: got %0d want 0", n_start); else n_pass++;
    cfg_req = 1'b1;
    tick(2);
    n_total++; if (cfg_grant !== 1'b1) $display("FAIL mid_cfg_grant: got %b want 1", cfg_grant); else n_pass++;
    ARESET = 1'b1;
    cfg_req = 1'b0;
    tick(1);
    n_total++; if (cfg_grant !== 1'b0) $display("FAIL mid_cfg_drop: got %b want 0", cfg_grant); else n_pass++;
    ARESET = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_cfg();
    test_wrap();
    test_reset_mid();
    tick(2);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
